// File: rtl/proc_hier.sv
// Minimal non-pipelined 16-bit core with per-cycle trace outputs.
// Optional: define STALL_MEM_EN to give every LD/ST a MEM_LAT-cycle data access.
module proc_hier #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8,
  parameter int MEM_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_we,
  input  logic [15:0] prog_addr,
  input  logic [15:0] prog_data,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        reg_write,
  output logic [2:0]  write_register,
  output logic [15:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_address,
  output logic [15:0] mem_data_in,
  output logic [15:0] mem_data_out,
  output logic        icache_req,
  output logic        icache_hit,
  output logic        dcache_req,
  output logic        dcache_hit,
  output logic        halt,
  output logic [31:0] cycle_count
);

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_ALU  = 5'b11011;
  localparam logic [4:0] OP_BEQZ = 5'b01100;
  localparam logic [4:0] OP_J    = 5'b00100;

  logic [15:0] imem [2**IMEM_AW];
  logic [15:0] dmem [2**DMEM_AW];
  logic [15:0] regs [8];

  logic [15:0] pc_r;
  logic        halted_r;
  logic [31:0] cyc_r;

  logic [15:0] cur_inst;
  logic [4:0]  op;
  logic [2:0]  rs, rt, rd;
  logic [1:0]  func;
  logic [15:0] rs_val, rt_val, imm5, ea, load_val;
  logic        is_ld, is_st, is_mem, mem_done, active, retire;
  logic [15:0] next_pc;
  logic        wen;
  logic [2:0]  wreg;
  logic [15:0] wdata;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{prog_addr[15:IMEM_AW+1], prog_addr[0]};

  assign cur_inst = imem[pc_r[IMEM_AW:1]];
  assign op       = cur_inst[15:11];
  assign rs       = cur_inst[10:8];
  assign rt       = cur_inst[7:5];
  assign rd       = cur_inst[4:2];
  assign func     = cur_inst[1:0];
  assign rs_val   = regs[rs];
  assign rt_val   = regs[rt];
  assign imm5     = {{11{cur_inst[4]}}, cur_inst[4:0]};
  assign ea       = rs_val + imm5;
  assign load_val = dmem[ea[DMEM_AW:1]];
  assign is_ld    = (op == OP_LD);
  assign is_st    = (op == OP_ST);
  assign is_mem   = is_ld | is_st;
  assign active   = ~rst & ~halted_r;
  assign retire   = active & (~is_mem | mem_done);

`ifdef STALL_MEM_EN
  localparam int SW = $clog2(MEM_LAT) + 1;
  logic [SW-1:0] stall_r;
  assign mem_done = (stall_r == SW'(MEM_LAT - 1));

  // Counts the wait cycles of the LD/ST at the current pc; reset aborts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r <= '0;
    end else if (active && is_mem && !mem_done) begin
      stall_r <= stall_r + SW'(1);
    end else begin
      stall_r <= '0;
    end
  end
`else
  assign mem_done = 1'b1;
`endif

  // Instruction decode: next pc and register write-back.
  always_comb begin
    next_pc = pc_r + 16'd2;
    wen     = 1'b0;
    wreg    = rt;
    wdata   = 16'd0;
    case (op)
      OP_HALT: next_pc = pc_r;
      OP_ADDI: begin
        wen   = 1'b1;
        wdata = rs_val + imm5;
      end
      OP_LD: begin
        wen   = 1'b1;
        wdata = load_val;
      end
      OP_ALU: begin
        wreg = rd;
        if (func == 2'b00) begin
          wen   = 1'b1;
          wdata = rs_val + rt_val;
        end else if (func == 2'b01) begin
          wen   = 1'b1;
          wdata = rs_val - rt_val;
        end else begin
          wen   = 1'b0;
        end
      end
      OP_BEQZ: begin
        if (rs_val == 16'd0) begin
          next_pc = pc_r + 16'd2 + {{8{cur_inst[7]}}, cur_inst[7:0]};
        end else begin
          next_pc = pc_r + 16'd2;
        end
      end
      OP_J:    next_pc = pc_r + 16'd2 + {{5{cur_inst[10]}}, cur_inst[10:0]};
      default: next_pc = pc_r + 16'd2;
    endcase
  end

  // Architectural state; memories are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= 16'd0;
      halted_r <= 1'b0;
      cyc_r    <= 32'd0;
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'd0;
      end
    end else begin
      cyc_r <= cyc_r + 32'd1;
      if (retire) begin
        pc_r <= next_pc;
        if (op == OP_HALT) begin
          halted_r <= 1'b1;
        end
        if (wen) begin
          regs[wreg] <= wdata;
        end
      end
    end
  end

  // Loader writes to imem and completing stores to dmem.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      imem[prog_addr[IMEM_AW:1]] <= prog_data;
    end
    if (retire && is_st) begin
      dmem[ea[DMEM_AW:1]] <= rt_val;
    end
  end

  assign pc             = pc_r;
  assign inst           = cur_inst;
  assign reg_write      = retire & wen;
  assign write_register = wreg;
  assign write_data     = wdata;
  assign mem_read       = retire & is_ld;
  assign mem_write      = retire & is_st;
  assign mem_address    = ea;
  assign mem_data_in    = rt_val;
  assign mem_data_out   = load_val;
  assign icache_req     = retire;
  assign icache_hit     = retire;
  assign dcache_req     = retire & is_mem;
  assign dcache_hit     = retire & is_mem;
  assign halt           = ~rst & (halted_r | (op == OP_HALT));
  assign cycle_count    = cyc_r;

endmodule

// File: tb/tb_proc_hier.sv
// Self-checking bench for proc_hier: instruction-level reference model compared every cycle.
module tb_proc_hier;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [15:0] prog_addr, prog_data;
  logic [15:0] pc, inst, write_data, mem_address, mem_data_in, mem_data_out;
  logic [2:0]  write_register;
  logic        reg_write, mem_read, mem_write, icache_req, icache_hit;
  logic        dcache_req, dcache_hit, halt;
  logic [31:0] cycle_count;

  proc_hier dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .pc(pc), .inst(inst), .reg_write(reg_write), .write_register(write_register),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .icache_req(icache_req), .icache_hit(icache_hit), .dcache_req(dcache_req),
    .dcache_hit(dcache_hit), .halt(halt), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

`ifdef STALL_MEM_EN
  localparam int LAT = 4;
`endif

  int total = 0;
  int bad = 0;

  // reference model state
  logic [15:0] prog   [256];
  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  logic [15:0] m_r    [8];
  logic [15:0] m_pc;
  logic [31:0] m_cyc;
  bit          m_halted;
  int          m_wait;

  // DUT observations for directed checks
  int          dut_ret;
  logic [15:0] dut_w [8];
  logic [15:0] cap_wa, cap_wd, cap_rd, halt_pc;
  bit          seen_halt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sx(input int v, input int nb);
    int s;
    s = v & ((1 << nb) - 1);
    if (s >= (1 << (nb - 1))) s = s - (1 << nb);
    return 16'(s);
  endfunction

  function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return 16'((op << 11) | (rs << 8) | (rt << 5) | (imm & 31));
  endfunction
  function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return 16'((27 << 11) | (rs << 8) | (rt << 5) | (rd << 2) | (fn & 3));
  endfunction
  function automatic logic [15:0] enc_b(input int rs, input int off);
    return 16'((12 << 11) | (rs << 8) | (off & 255));
  endfunction
  function automatic logic [15:0] enc_j(input int off);
    return 16'((4 << 11) | (off & 2047));
  endfunction

  localparam logic [15:0] NOP  = 16'h0800;
  localparam logic [15:0] HALT = 16'h0000;

  task automatic model_reset();
    m_pc = 16'd0; m_cyc = 32'd0; m_halted = 1'b0; m_wait = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'd0;
  endtask

  task automatic clear_obs();
    dut_ret = 0; seen_halt = 1'b0; halt_pc = 16'hxxxx;
    cap_wa = 16'd0; cap_wd = 16'd0; cap_rd = 16'd0;
    for (int i = 0; i < 8; i++) dut_w[i] = 16'hxxxx;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) prog[i] = NOP;
  endtask

  // Holds rst high and writes all 256 imem words from prog[].
  task automatic load_prog();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      prog_we = 1'b1; prog_addr = 16'(i * 2); prog_data = prog[i];
      m_imem[i] = prog[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
    @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  // One-cycle reset from a negedge; strobes must be quiet while rst is high.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_icache", 32'(icache_req), 32'd0);
    check("rst_dcache", 32'(dcache_req), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_pc", 32'(pc), 32'd0);
    check("post_rst_cyc", cycle_count, 32'd0);
  endtask

  // Compare all trace outputs for this cycle against the model, then advance the model.
  task automatic cycle_check();
    logic [15:0] ins, a, b, ea, nxt, e_wd;
    int op, rs, rt, rd, fn, e_wr;
    bit e_ret, e_rw, e_mr, e_mw, was_halted;
    ins = m_imem[m_pc[8:1]];
    op = int'(ins[15:11]); rs = int'(ins[10:8]); rt = int'(ins[7:5]);
    rd = int'(ins[4:2]); fn = int'(ins[1:0]);
    a = m_r[rs]; b = m_r[rt];
    ea = a + sx(int'(ins[4:0]), 5);
    was_halted = m_halted;
    e_ret = !m_halted; e_rw = 0; e_mr = 0; e_mw = 0; e_wr = 0; e_wd = 16'd0;
    nxt = m_pc + 16'd2;
    if (!m_halted) begin
      case (op)
        0:  nxt = m_pc;
        8:  begin e_rw = 1; e_wr = rt; e_wd = ea; end
        16: e_mw = 1;
        17: begin e_mr = 1; e_rw = 1; e_wr = rt; e_wd = m_dmem[ea[8:1]]; end
        27: begin
          if (fn == 0) begin e_rw = 1; e_wr = rd; e_wd = a + b; end
          if (fn == 1) begin e_rw = 1; e_wr = rd; e_wd = a - b; end
        end
        12: if (a == 16'd0) nxt = m_pc + 16'd2 + sx(int'(ins[7:0]), 8);
        4:  nxt = m_pc + 16'd2 + sx(int'(ins[10:0]), 11);
        default: ;
      endcase
`ifdef STALL_MEM_EN
      if ((op == 16 || op == 17) && m_wait < LAT - 1) begin
        e_ret = 0; e_rw = 0; e_mr = 0; e_mw = 0;
      end
`endif
    end

    check("pc", 32'(pc), 32'(m_pc));
    check("inst", 32'(inst), 32'(ins));
    check("halt", 32'(halt), 32'(m_halted || op == 0));
    check("reg_write", 32'(reg_write), 32'(e_rw));
    if (e_rw) begin
      check("write_register", 32'(write_register), 32'(e_wr));
      check("write_data", 32'(write_data), 32'(e_wd));
    end
    check("mem_read", 32'(mem_read), 32'(e_mr));
    check("mem_write", 32'(mem_write), 32'(e_mw));
    if (e_mr || e_mw) check("mem_address", 32'(mem_address), 32'(ea));
    if (e_mw) check("mem_data_in", 32'(mem_data_in), 32'(b));
    if (e_mr) check("mem_data_out", 32'(mem_data_out), 32'(e_wd));
    check("icache_req", 32'(icache_req), 32'(e_ret));
    check("icache_hit", 32'(icache_hit), 32'(e_ret));
    check("dcache_req", 32'(dcache_req), 32'(e_mr | e_mw));
    check("dcache_hit", 32'(dcache_hit), 32'(e_mr | e_mw));
    check("cycle_count", cycle_count, m_cyc);

    if (icache_req === 1'b1) dut_ret++;
    if (reg_write === 1'b1) dut_w[write_register] = write_data;
    if (mem_write === 1'b1) begin cap_wa = mem_address; cap_wd = mem_data_in; end
    if (mem_read === 1'b1) cap_rd = mem_data_out;
    if (halt === 1'b1 && !seen_halt) begin seen_halt = 1'b1; halt_pc = pc; end

    m_cyc = m_cyc + 32'd1;
    if (e_ret) begin
      m_pc = nxt;
      if (op == 0) m_halted = 1'b1;
      if (e_rw) m_r[e_wr] = e_wd;
      if (e_mw) m_dmem[ea[8:1]] = b;
    end
    if (!was_halted && (op == 16 || op == 17) && !e_ret) m_wait++;
    else m_wait = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      #1;
      cycle_check();
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] rand_inst();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 25) return enc_i(8, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
    if (r < 35) return enc_i(16, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
    if (r < 45) return enc_i(17, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom));
    if (r < 65) return enc_r(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                             int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    if (r < 75) return enc_b(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    if (r < 82) return enc_j(int'($urandom_range(0, 2047)));
    if (r < 84) return HALT;
    if (r < 90) return NOP;
    return 16'($urandom);
  endfunction

  initial begin
    logic [15:0] val;
    int k;
    rst = 1'b1; prog_we = 1'b0; prog_addr = 16'd0; prog_data = 16'd0;
    for (int i = 0; i < 256; i++) m_dmem[i] = 16'd0;
    repeat (2) @(negedge clk);

    // Zero every data word: ST R0,[R1]; R1 += 2; jump back.
    fill_nop();
    prog[0] = enc_i(16, 1, 0, 0);
    prog[1] = enc_i(8, 1, 1, 2);
    prog[2] = enc_j(-6);
    load_prog();
    run(1600);

    // ADDI/ADDI/ADD/HALT, then idle cycles while halted.
    fill_nop();
    prog[0] = enc_i(8, 0, 1, 5);
    prog[1] = enc_i(8, 0, 2, -3);
    prog[2] = enc_r(1, 2, 3, 0);
    prog[3] = HALT;
    load_prog(); clear_obs();
    run(10);
    check("p1_r1", 32'(dut_w[1]), 32'h0005);
    check("p1_r2", 32'(dut_w[2]), 32'hfffd);
    check("p1_r3", 32'(dut_w[3]), 32'h0002);
    check("p1_halt_pc", 32'(halt_pc), 32'h0006);
    check("p1_retired", 32'(dut_ret), 32'd4);
    check("p1_halt_hold", 32'(halt), 32'd1);

    // Build 0x1234 in R1, store to [R0+4], load into R4.
    fill_nop();
    val = 16'h1234; k = 0;
    prog[k++] = enc_i(8, 0, 1, 1);
    for (int bi = 11; bi >= 0; bi--) begin
      prog[k++] = enc_r(1, 1, 1, 0);
      if (val[bi]) prog[k++] = enc_i(8, 1, 1, 1);
    end
    prog[k++] = enc_i(16, 0, 1, 4);
    prog[k++] = enc_i(17, 0, 4, 4);
    prog[k++] = HALT;
    load_prog(); clear_obs();
    run(k + 12);
    check("p2_st_addr", 32'(cap_wa), 32'h0004);
    check("p2_st_data", 32'(cap_wd), 32'h1234);
    check("p2_ld_data", 32'(cap_rd), 32'h1234);
    check("p2_r4", 32'(dut_w[4]), 32'h1234);

    // Branches, SUB wrap and a J self-loop.
    fill_nop();
    prog[0]  = enc_i(8, 0, 2, 1);
    prog[1]  = enc_r(1, 2, 5, 1);
    prog[8]  = enc_b(1, 4);
    prog[9]  = HALT;
    prog[10] = HALT;
    prog[11] = enc_b(2, 4);
    prog[12] = enc_j(-2);
    load_prog(); clear_obs();
    run(20);
    check("p3_sub", 32'(dut_w[5]), 32'hffff);
    check("p3_selfloop_pc", 32'(pc), 32'h0018);
    check("p3_no_halt", 32'(seen_halt), 32'd0);

    // Signed overflow: 0x7FFF + 1.
    fill_nop(); k = 0;
    prog[k++] = enc_i(8, 0, 1, 1);
    for (int i = 0; i < 15; i++) prog[k++] = enc_r(1, 1, 1, 0);
    prog[k++] = enc_i(8, 1, 1, -1);
    prog[k++] = enc_i(8, 1, 1, 1);
    prog[k++] = HALT;
    load_prog(); clear_obs();
    run(k + 3);
    check("p4_overflow", 32'(dut_w[1]), 32'h8000);

    // Random programs with a mid-run reset pulse.
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) prog[i] = rand_inst();
      load_prog();
      run(int'($urandom_range(5, 150)));
      pulse_reset();
      run(150);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_hier.md
Name: proc_hier

Overview:
- Top of the processor hierarchy: a minimal non-pipelined 16-bit core with eight 16-bit registers, a word-addressed instruction memory, a data memory and a free-running cycle counter.
- Retires at most one instruction per cycle.
- Exports per-cycle trace signals: PC, instruction, register write, memory access, cache-event counts and halt. The performance bench uses these to build the simulation log and the instruction trace.

Parameters:
- IMEM_AW, 8, instruction memory word-address width (2^IMEM_AW words).
- DMEM_AW, 8, data memory word-address width.
- MEM_LAT, 4, data-access latency in cycles when STALL_MEM_EN is defined (must be ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- prog_we  in  1  instruction-memory write strobe (loader)
- prog_addr  in  16  byte address of the instruction word; bits [IMEM_AW:1] are used
- prog_data  in  16  instruction word to write
- pc  out  16  byte address of the current instruction
- inst  out  16  current instruction word
- reg_write  out  1  register file written this cycle
- write_register  out  3  destination register
- write_data  out  16  value written
- mem_read  out  1  load completes this cycle
- mem_write  out  1  store completes this cycle
- mem_address  out  16  effective address
- mem_data_in  out  16  store data
- mem_data_out  out  16  load data
- icache_req, icache_hit, dcache_req, dcache_hit  out  1 each  cache-event strobes
- halt  out  1  HALT executed
- cycle_count  out  32  cycles since reset deassertion

Behaviour:
- Reset: pc=0, registers R0–R7=0, cycle_count=0, halted flag=0. All trace strobes are 0 while rst=1. Memory contents are not reset.
- prog_we writes imem on the clock edge and is accepted at any time. Loading is intended while rst=1.
- Memories are read asynchronously. Writes occur on the clock edge. Addresses are byte addresses; the word index is addr[AW:1]; bit 0 is ignored.
- Instruction fields: op=inst[15:11], Rs=[10:8], Rt=[7:5], Rd=[4:2], sext = sign extension.
- Encodings:
  - 00000 HALT.
  - 00001 NOP.
  - 01000 ADDI: R[Rt] = R[Rs] + sext(inst[4:0]).
  - 10000 ST: Mem[R[Rs] + sext(inst[4:0])] = R[Rt].
  - 10001 LD: R[Rt] = Mem[R[Rs] + sext(inst[4:0])].
  - 11011 ALU: R[Rd] = R[Rs] + R[Rt] when func inst[1:0]=00; R[Rs] − R[Rt] when func=01; other func values are NOP.
  - 01100 BEQZ: if R[Rs]==0, pc = pc + 2 + sext(inst[7:0]).
  - 00100 J: pc = pc + 2 + sext(inst[10:0]).
  - Any other opcode is a NOP.
- Non-branching instructions advance pc by 2. Arithmetic is mod 2^16 with wrap-around and no flags. PC wraps at 16 bits.
- Retire cycle: reg_write/write_register/write_data are valid in the same cycle as the architectural write, which takes effect on that edge.
- mem_read/mem_write together with address and data are valid in the completing cycle of the access.
- A register read of the register written in the same cycle returns the old value.
- HALT: halt=1 in the HALT cycle and stays 1 until reset. pc freezes and no further strobes are issued except halt.
- cycle_count increments every cycle while rst=0, including while halted. It wraps at 2^32.
- icache_req=icache_hit=1 in every cycle in which an instruction retires.
- dcache_req=1 in the completing cycle of each LD/ST.

Optional Feature:
- STALL_MEM_EN defined:
  - Each LD/ST holds pc and inst for MEM_LAT cycles.
  - mem_*, reg_write and dcache_req assert only in the final cycle.
  - dcache_hit=0 and icache_req=0 during the stall cycles.
  - rst during a stall aborts the access; no write occurs.
- STALL_MEM_EN undefined: LD/ST complete in one cycle, and dcache_hit=dcache_req.

Test Plan:
- Reset, then the program ADDI R1,R0,5; ADDI R2,R0,-3; ALU ADD R3=R1+R2; HALT -> trace shows REG 1=0x0005, REG 2=0xFFFD, REG 3=0x0002, then halt=1 at pc=0x0006; instructions retired = 4.
- ST R1→[R0+4] then LD R4←[R0+4], with R1=0x1234 -> mem_write at addr 0x0004 with data 0x1234; mem_read returns 0x1234; REG 4=0x1234. With STALL_MEM_EN and MEM_LAT=4, the LD retires 4 cycles after issue.
- BEQZ taken/not taken: R1=0 with offset +4 at pc=0x0010 -> next pc 0x0016; R1≠0 -> next pc 0x0012. J with disp −2 -> self-loop at the same pc.
- Overflow: R1=0x7FFF, ADDI R1,R1,1 -> 0x8000. R1=0 then SUB R2 = R1 − R2 with R2=1 -> 0xFFFF.
- Assert rst for 1 cycle mid-program (mid-stall when STALL_MEM_EN is defined) -> pc=0, registers=0, cycle_count restarts at 0, no spurious mem_write.
- HALT, then 5 further cycles -> halt stays 1, pc is unchanged, cycle_count keeps incrementing, no reg_write/mem strobes.
